pfp_run_ctl: RTL and testbench

Run/stop/single-step controller for the PFP front-panel board. Debounces the front-panel RUN, STOP and STEP switches and accepts a software halt request via an I/O write to `PFP_HALT` (0x0037). It sequences the machine through run, halted and single-step states by driving the open-drain `ec_nhalt` line. It also exposes a status word at `PFP_BASE` (0x0030) on the I/O bus.

---
 rtl/pfp_run_ctl_pkg.sv | 36 +++
 rtl/pfp_debounce.sv | 62 ++++++
 rtl/pfp_run_ctl.sv | 138 +++++++++++++
 tb/tb_pfp_run_ctl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfp_run_ctl_pkg.sv
// Shared definitions for the PFP front-panel run/stop/step controller:
// I/O addresses, FSM state encoding, status-word layout and its builder.
package pfp_run_ctl_pkg;

  // I/O map (decoded only while ec_nsysdev is low)
  localparam logic [15:0] PFP_BASE   = 16'h0030;
  localparam logic [15:0] PFP_STATUS = PFP_BASE;
  localparam logic [15:0] PFP_HALT   = 16'h0037;

  // Machine state encoding
  typedef enum logic [1:0] {
    PFP_ST_RUN    = 2'd0,
    PFP_ST_HALTED = 2'd1,
    PFP_ST_STEP   = 2'd2
  } pfp_state_e;

  // Status word bit positions
  localparam int STAT_RUN_BIT   = 0;
  localparam int STAT_HALT_BIT  = 1;
  localparam int STAT_STEP_BIT  = 2;
  localparam int STAT_COUNT_LSB = 8;

  // Assemble the status word: step count in the upper byte, one-hot state
  // flags in the low bits, everything else reads as zero.
  function automatic logic [15:0] status_word(input pfp_state_e st,
                                              input logic [7:0] cnt);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_COUNT_LSB +: 8] = cnt;
    w[STAT_RUN_BIT]        = (st == PFP_ST_RUN);
    w[STAT_HALT_BIT]       = (st == PFP_ST_HALTED);
    w[STAT_STEP_BIT]       = (st == PFP_ST_STEP);
    return w;
  endfunction

endpackage

// File: rtl/pfp_debounce.sv
// Switch debouncer: two-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted 0->1 transition.
module pfp_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int              CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_p0;
  logic             sync_p1;
  logic             accepted;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             flip;

  // The accepted level flips on the CYCLES-th consecutive disagreeing sample
  assign differ = sync_p1 ^ accepted;
  assign flip   = differ && (cnt == CNT_LAST);

  // Synchroniser for the asynchronous contact
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive disagreeing samples; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!differ || flip) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Accepted level and registered press pulse (releases are silent)
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= flip && !accepted;
      if (flip) begin
        accepted <= ~accepted;
      end
    end
  end

endmodule

// File: rtl/pfp_run_ctl.sv
// PFP front-panel run/stop/single-step controller. Debounces the panel
// switches, decodes the software halt write, sequences the machine through
// RUN / HALTED / STEP via the open-drain ec_nhalt line and serves a status
// word on the I/O bus.
module pfp_run_ctl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit START_HALTED    = 1'b0
) (
  input  logic        ec_clk4,
  input  logic        ec_reset,
  input  logic [15:0] ec_ab,
  inout  wire  [15:0] ec_db,
  input  logic        ec_nsysdev,
  input  logic        ec_nr,
  input  logic        ec_nw,
  inout  wire         ec_nhalt,
  input  logic        sw_run,
  input  logic        sw_stop,
  input  logic        sw_step,
  input  logic        insn_done,
  output logic        led_run,
  output logic        led_halt,
  output logic        led_step
);

  import pfp_run_ctl_pkg::*;

  localparam pfp_state_e RESET_STATE = START_HALTED ? PFP_ST_HALTED : PFP_ST_RUN;

  logic       run_press;
  logic       stop_press;
  logic       step_press;
  logic       nw_q;
  logic       halt_wr;
  logic       rd_sel;
  logic       count_inc;
  logic [7:0] step_count;
  pfp_state_e state;
  pfp_state_e state_nxt;

  pfp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk   (ec_clk4),
    .rst   (ec_reset),
    .raw   (sw_run),
    .press (run_press)
  );

  pfp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk   (ec_clk4),
    .rst   (ec_reset),
    .raw   (sw_stop),
    .press (stop_press)
  );

  pfp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk   (ec_clk4),
    .rst   (ec_reset),
    .raw   (sw_step),
    .press (step_press)
  );

  // Previous write strobe, so a long strobe is seen as a single falling edge
  always_ff @(posedge ec_clk4) begin
    if (ec_reset) begin
      nw_q <= 1'b1;
    end else begin
      nw_q <= ec_nw;
    end
  end

  // Halt write: falling strobe edge on the halt address; data is ignored
  assign halt_wr = !ec_nw && nw_q && !ec_nsysdev && (ec_ab == PFP_HALT);

  // State register
  always_ff @(posedge ec_clk4) begin
    if (ec_reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop >= halt write > run > step
  always_comb begin
    state_nxt = state;
    count_inc = 1'b0;
    case (state)
      PFP_ST_RUN: begin
        if (stop_press || halt_wr) begin
          state_nxt = PFP_ST_HALTED;
        end
      end
      PFP_ST_HALTED: begin
        if (stop_press || halt_wr) begin
          state_nxt = PFP_ST_HALTED;
        end else if (run_press) begin
          state_nxt = PFP_ST_RUN;
        end else if (step_press) begin
          state_nxt = PFP_ST_STEP;
        end
      end
      PFP_ST_STEP: begin
        // A stop aborts the step uncounted, even alongside insn_done
        if (stop_press) begin
          state_nxt = PFP_ST_HALTED;
        end else if (insn_done) begin
          state_nxt = PFP_ST_HALTED;
          count_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = PFP_ST_HALTED;
      end
    endcase
  end

  // Completed single steps, 8-bit wrapping
  always_ff @(posedge ec_clk4) begin
    if (ec_reset) begin
      step_count <= 8'd0;
    end else if (count_inc) begin
      step_count <= step_count + 8'd1;
    end
  end

  // Decoded state indicators
  assign led_run  = (state == PFP_ST_RUN);
  assign led_halt = (state == PFP_ST_HALTED);
  assign led_step = (state == PFP_ST_STEP);

  // Open-drain halt: pull low only while halted, never drive high
  assign ec_nhalt = led_halt ? 1'b0 : 1'bz;

  // Combinational status read from registered state
  assign rd_sel = !ec_nsysdev && !ec_nr && (ec_ab == PFP_STATUS);
  assign ec_db  = rd_sel ? status_word(state, step_count) : 16'hzzzz;

endmodule

// File: tb/tb_pfp_run_ctl.sv
// Testbench for pfp_run_ctl: table-driven bus vectors, directed multi-cycle
// sequences, then randomized traffic against a behavioural reference model.
module tb_pfp_run_ctl;

  localparam int C  = 4;
  localparam int NR = 3000;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ab;
  logic        nsysdev, nr, nw;
  logic        sw_run, sw_stop, sw_step, insn_done;
  logic        led_run, led_halt, led_step;
  wire  [15:0] db;
  wire         nhalt;

  // Board pull-ups: a released line reads as 1
  pullup pu_nhalt (nhalt);
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pu_db (db[g]);
  end

  always #5 clk = ~clk;

  pfp_run_ctl #(.DEBOUNCE_CYCLES(C), .START_HALTED(1'b0)) dut (
    .ec_clk4    (clk),
    .ec_reset   (rst),
    .ec_ab      (ab),
    .ec_db      (db),
    .ec_nsysdev (nsysdev),
    .ec_nr      (nr),
    .ec_nw      (nw),
    .ec_nhalt   (nhalt),
    .sw_run     (sw_run),
    .sw_stop    (sw_stop),
    .sw_step    (sw_step),
    .insn_done  (insn_done),
    .led_run    (led_run),
    .led_halt   (led_halt),
    .led_step   (led_step)
  );

  typedef struct {
    logic        nsysdev;
    logic        nr;
    logic [15:0] ab;
    logic [15:0] exp_db;
  } rd_vec_t;

  typedef struct {
    logic        nsysdev;
    logic [15:0] ab;
    logic        exp_halt;
  } wr_vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_leds(input string name, input logic [2:0] exp_rhs);
    chk({name, "_leds"}, {29'd0, led_run, led_halt, led_step}, {29'd0, exp_rhs});
    chk({name, "_nhalt"}, {31'd0, nhalt}, {31'd0, !exp_rhs[1]});
  endtask

  task automatic idle();
    ab = 16'h0000; nsysdev = 1'b1; nr = 1'b1; nw = 1'b1;
    sw_run = 1'b0; sw_stop = 1'b0; sw_step = 1'b0; insn_done = 1'b0;
  endtask

  task automatic rd_status(output logic [15:0] v);
    nsysdev = 1'b0; nr = 1'b0; ab = 16'h0030;
    #1 v = db;
    nr = 1'b1; nsysdev = 1'b1; ab = 16'h0000;
  endtask

  task automatic chk_status(input string name, input logic [15:0] exp);
    logic [15:0] v;
    rd_status(v);
    chk(name, {16'd0, v}, {16'd0, exp});
  endtask

  task automatic press_sw(input int which);
    case (which)
      0: sw_run = 1'b1;
      1: sw_stop = 1'b1;
      default: sw_step = 1'b1;
    endcase
    repeat (C + 4) @(negedge clk);
    sw_run = 1'b0; sw_stop = 1'b0; sw_step = 1'b0;
    repeat (C + 4) @(negedge clk);
  endtask

  task automatic do_step();
    press_sw(2);
    insn_done = 1'b1;
    @(negedge clk);
    insn_done = 1'b0;
    @(negedge clk);
  endtask

  // Reference model state
  bit   hist [3][NR];
  bit   m_acc [3];
  bit   m_press [3];
  int   m_lastflip [3];
  int   m_lastrst;
  int   m_mode;
  logic [7:0] m_cnt;
  bit   m_nwprev;

  // Sample the comparator sees at edge x: the raw value two edges earlier,
  // or the reset value if that is not yet past the last reset
  function automatic bit samp(input int i, input int x);
    if (x - 2 > m_lastrst) return hist[i][x-2];
    return 1'b0;
  endfunction

  rd_vec_t rd_tab[6];
  wr_vec_t wr_tab[5];

  initial begin
    logic [15:0] ab_pool [6];
    logic [2:0]  swv;
    logic [2:0]  exp3;
    logic [15:0] exp_db;
    bit          wr, all_diff;
    bit          p [3];

    rd_tab[0] = '{1'b0, 1'b0, 16'h0030, 16'h0001};
    rd_tab[1] = '{1'b1, 1'b0, 16'h0030, 16'hFFFF};
    rd_tab[2] = '{1'b0, 1'b1, 16'h0030, 16'hFFFF};
    rd_tab[3] = '{1'b0, 1'b0, 16'h0031, 16'hFFFF};
    rd_tab[4] = '{1'b0, 1'b0, 16'h0130, 16'hFFFF};
    rd_tab[5] = '{1'b0, 1'b0, 16'h0037, 16'hFFFF};

    wr_tab[0] = '{1'b0, 16'h0035, 1'b0};
    wr_tab[1] = '{1'b0, 16'h0137, 1'b0};
    wr_tab[2] = '{1'b1, 16'h0037, 1'b0};
    wr_tab[3] = '{1'b0, 16'h0030, 1'b0};
    wr_tab[4] = '{1'b0, 16'h0037, 1'b1};

    ab_pool[0] = 16'h0030; ab_pool[1] = 16'h0037; ab_pool[2] = 16'h0035;
    ab_pool[3] = 16'h0031; ab_pool[4] = 16'h0137; ab_pool[5] = 16'h0037;

    // Reset
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_leds("reset", 3'b100);
    chk("reset_db_idle", {16'd0, db}, {16'd0, 16'hFFFF});

    // Read decode table
    for (int i = 0; i < 6; i++) begin
      nsysdev = rd_tab[i].nsysdev; nr = rd_tab[i].nr; ab = rd_tab[i].ab;
      #1 chk($sformatf("rd_tab%0d", i), {16'd0, db}, {16'd0, rd_tab[i].exp_db});
      idle();
      @(negedge clk);
    end

    // Write decode table; only the last vector hits the halt address
    for (int i = 0; i < 5; i++) begin
      nsysdev = wr_tab[i].nsysdev; ab = wr_tab[i].ab; nw = 1'b0;
      #1 chk($sformatf("wr_tab%0d_pre", i), {31'd0, led_halt}, 32'd0);
      @(negedge clk);
      chk($sformatf("wr_tab%0d_halt", i), {31'd0, led_halt}, {31'd0, wr_tab[i].exp_halt});
      chk($sformatf("wr_tab%0d_nhalt", i), {31'd0, nhalt}, {31'd0, !wr_tab[i].exp_halt});
      idle();
      @(negedge clk);
    end
    chk_status("status_halted", 16'h0002);

    // Strobe already low when the address moves onto the halt register
    press_sw(0);
    chk_leds("run_again", 3'b100);
    nsysdev = 1'b0; ab = 16'h0035; nw = 1'b0;
    repeat (3) @(negedge clk);
    ab = 16'h0037;
    repeat (3) @(negedge clk);
    chk_leds("held_strobe_moved", 3'b100);
    idle();
    @(negedge clk);
    nsysdev = 1'b0; ab = 16'h0037; nw = 1'b0;
    repeat (6) @(negedge clk);
    idle();
    @(negedge clk);
    chk_leds("long_strobe_halt", 3'b010);

    // Single step with exact latencies
    sw_step = 1'b1;
    repeat (C + 2) @(negedge clk);
    chk_leds("step_before", 3'b010);
    @(negedge clk);
    chk_leds("step_entered", 3'b001);
    repeat (10 - (C + 3)) @(negedge clk);
    sw_step = 1'b0;
    repeat (5) @(negedge clk);
    insn_done = 1'b1;
    #1 chk_leds("step_window", 3'b001);
    @(negedge clk);
    insn_done = 1'b0;
    chk_leds("step_done", 3'b010);
    chk_status("status_one_step", 16'h0102);
    repeat (C + 4) @(negedge clk);

    // Count wrap
    for (int i = 0; i < 254; i++) do_step();
    chk_status("status_255", 16'hFF02);
    do_step();
    chk_status("status_wrap", 16'h0002);

    // Short glitch on STEP is filtered
    sw_step = 1'b1;
    repeat (3) @(negedge clk);
    sw_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk({"glitch_", $sformatf("%0d", i)}, {29'd0, led_run, led_halt, led_step}, 32'd2);
    end

    // STOP and RUN pressed together while running
    press_sw(0);
    chk_leds("run_for_tie", 3'b100);
    sw_run = 1'b1; sw_stop = 1'b1;
    repeat (C + 4) @(negedge clk);
    sw_run = 1'b0; sw_stop = 1'b0;
    repeat (C + 4) @(negedge clk);
    chk_leds("stop_run_tie", 3'b010);

    // stop_press coinciding with insn_done in STEP
    press_sw(2);
    chk_leds("step_for_stop", 3'b001);
    sw_stop = 1'b1;
    repeat (C + 2) @(negedge clk);
    insn_done = 1'b1;
    #1 chk_leds("stop_insn_pre", 3'b001);
    @(negedge clk);
    insn_done = 1'b0;
    chk_leds("stop_insn_post", 3'b010);
    chk_status("stop_insn_count", 16'h0002);
    sw_stop = 1'b0;
    repeat (C + 4) @(negedge clk);

    // Reset in the middle of a step
    do_step();
    chk_status("count_before_rst", 16'h0102);
    press_sw(2);
    chk_leds("step_for_rst", 3'b001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk_leds("rst_in_step", 3'b100);
    chk_status("rst_in_step_status", 16'h0001);
    @(negedge clk);

    // Randomized traffic against the reference model
    swv = 3'b000;
    for (int e = 0; e < NR; e++) begin
      rst = (e == 0) || ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 11) == 0) swv[i] = ~swv[i];
      {sw_step, sw_stop, sw_run} = swv;
      insn_done = ($urandom_range(0, 5) == 0);
      nw        = ($urandom_range(0, 4) != 0);
      nsysdev   = ($urandom_range(0, 3) == 0);
      nr        = ($urandom_range(0, 2) != 0);
      ab        = ab_pool[$urandom_range(0, 5)];
      #1;
      if (e > 0) begin
        exp3 = {m_mode == M_RUN, m_mode == M_HALT, m_mode == M_STEP};
        exp_db = (!nsysdev && !nr && ab == 16'h0030) ?
                 {m_cnt, 5'b00000, exp3[0], exp3[1], exp3[2]} : 16'hFFFF;
        chk("rnd_leds", {29'd0, led_run, led_halt, led_step}, {29'd0, exp3});
        chk("rnd_nhalt", {31'd0, nhalt}, {31'd0, m_mode != M_HALT});
        chk("rnd_db", {16'd0, db}, {16'd0, exp_db});
      end
      @(posedge clk);
      hist[0][e] = sw_run; hist[1][e] = sw_stop; hist[2][e] = sw_step;
      if (rst) begin
        m_mode = M_RUN; m_cnt = 8'd0; m_nwprev = 1'b1; m_lastrst = e;
        for (int i = 0; i < 3; i++) begin
          m_acc[i] = 1'b0; m_press[i] = 1'b0; m_lastflip[i] = e;
        end
      end else begin
        wr = !nw && m_nwprev && !nsysdev && (ab == 16'h0037);
        m_nwprev = nw;
        p = m_press;
        case (m_mode)
          M_RUN:  if (p[1] || wr) m_mode = M_HALT;
          M_HALT: if (!(p[1] || wr)) begin
                    if (p[0]) m_mode = M_RUN;
                    else if (p[2]) m_mode = M_STEP;
                  end
          default: if (p[1]) m_mode = M_HALT;
                   else if (insn_done) begin
                     m_mode = M_HALT;
                     m_cnt  = m_cnt + 8'd1;
                   end
        endcase
        // A switch is accepted once its last C samples since the previous
        // acceptance all disagree with the accepted level
        for (int i = 0; i < 3; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < C; k++)
            if ((e - k) <= m_lastflip[i] || samp(i, e - k) == m_acc[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_acc[i] = ~m_acc[i];
            m_lastflip[i] = e;
            m_press[i] = m_acc[i];
          end else begin
            m_press[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
